// File: rtl/col_theta_apply.sv
// -----------------------------------------------------------------------------
// col_theta_apply
//
// Applies the column-parity correction to every slice of the state. For slice
// z the 5-bit column parity C_z (taken from the parity stage) and the parity of
// the previous slice C_{z-1} (wrapping: slice 0 uses slice LINES-1) combine into
//    D[x] = C_z[(x+4)%5] ^ C_{z-1}[(x+1)%5]
// and D[x] is XORed into bit 5*y+x of the slice for every row y. The corrected
// slices are streamed out with one write pulse per slice, every other cycle.
//
// Ports
//    clk          single clock, all state updates on the rising edge
//    rst          synchronous active-high reset
//    start        level run request, sampled only while idle
//    donee        high while the run is finished and start is still held
//    cnt_value    slice-memory read address (memory answers in the same cycle)
//    line_in      slice word read from cnt_value
//    par_addr     parity-memory read address (memory answers in the same cycle)
//    par_in       parity word read from par_addr; only bits [4:0] are used
//    write_enable one-cycle pulse per corrected slice
//    write_addr   slice index belonging to write_value
//    write_value  corrected slice
// -----------------------------------------------------------------------------
module col_theta_apply #(
   parameter int LINES = 64,
   parameter int W     = 25,
   localparam int AW   = $clog2(LINES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          donee,
   output logic [AW-1:0] cnt_value,
   input  logic [W-1:0]  line_in,
   output logic [AW-1:0] par_addr,
   input  logic [W-1:0]  par_in,
   output logic          write_enable,
   output logic [AW-1:0] write_addr,
   output logic [W-1:0]  write_value
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRIME = 3'd1,
      READ  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [AW-1:0] ZERO_Z = AW'(0);
   localparam logic [AW-1:0] ONE_Z  = AW'(1);
   localparam logic [AW-1:0] LAST_Z = AW'(LINES - 1);
   localparam logic [W-1:0]  ZERO_W = W'(0);

   // Correction term per column from the current and previous slice parity.
   function automatic logic [4:0] theta_d(input logic [4:0] cur, input logic [4:0] prv);
      logic [4:0] d;
      d[0] = cur[4] ^ prv[1];
      d[1] = cur[0] ^ prv[2];
      d[2] = cur[1] ^ prv[3];
      d[3] = cur[2] ^ prv[4];
      d[4] = cur[3] ^ prv[0];
      return d;
   endfunction

   // Replicate the per-column term into all five rows (bit 5*y+x gets d[x]).
   function automatic logic [24:0] spread_rows(input logic [4:0] d);
      return {5{d}};
   endfunction

   state_t          state_r;
   state_t          state_nxt_s;
   logic [AW-1:0]   z_r;
   logic [4:0]      prev_r;
   logic            donee_r;
   logic            write_enable_r;
   logic [AW-1:0]   cnt_value_r;
   logic [AW-1:0]   par_addr_r;
   logic [AW-1:0]   write_addr_r;
   logic [W-1:0]    write_value_r;

   logic [4:0]      cur_s;
   logic [4:0]      d_s;
   logic [W-1:0]    corrected_s;
   logic            last_slice_s;

   assign cur_s        = par_in[4:0];
   assign d_s          = theta_d(cur_s, prev_r);
   assign corrected_s  = line_in ^ W'(spread_rows(d_s));
   assign last_slice_s = (z_r == LAST_Z);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; start is only looked at in IDLE and DONE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = PRIME;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         PRIME: state_nxt_s = READ;
         READ:  state_nxt_s = WRITE;
         WRITE: begin
            if (last_slice_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = READ;
            end
         end
         DONE: begin
            if (!start) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath and registered outputs. Read addresses are set one edge ahead so
   // they are valid for the whole cycle of the state that uses them.
   always_ff @(posedge clk) begin
      if (rst) begin
         z_r            <= ZERO_Z;
         prev_r         <= 5'd0;
         donee_r        <= 1'b0;
         write_enable_r <= 1'b0;
         cnt_value_r    <= ZERO_Z;
         par_addr_r     <= ZERO_Z;
         write_addr_r   <= ZERO_Z;
         write_value_r  <= ZERO_W;
      end else begin
         case (state_r)
            IDLE: begin
               donee_r        <= 1'b0;
               write_enable_r <= 1'b0;
               if (start) begin
                  // PRIME fetches the last slice's parity for the wrap term.
                  par_addr_r <= LAST_Z;
               end else begin
                  par_addr_r <= ZERO_Z;
               end
            end
            PRIME: begin
               prev_r      <= cur_s;
               z_r         <= ZERO_Z;
               cnt_value_r <= ZERO_Z;
               par_addr_r  <= ZERO_Z;
            end
            READ: begin
               write_value_r  <= corrected_s;
               write_addr_r   <= z_r;
               prev_r         <= cur_s;
               write_enable_r <= 1'b1;
            end
            WRITE: begin
               write_enable_r <= 1'b0;
               if (last_slice_s) begin
                  donee_r     <= 1'b1;
                  cnt_value_r <= ZERO_Z;
                  par_addr_r  <= ZERO_Z;
               end else begin
                  z_r         <= z_r + ONE_Z;
                  cnt_value_r <= z_r + ONE_Z;
                  par_addr_r  <= z_r + ONE_Z;
               end
            end
            DONE: begin
               write_enable_r <= 1'b0;
               if (!start) begin
                  // Returning to IDLE restores every output to its reset value.
                  donee_r       <= 1'b0;
                  z_r           <= ZERO_Z;
                  prev_r        <= 5'd0;
                  write_addr_r  <= ZERO_Z;
                  write_value_r <= ZERO_W;
               end else begin
                  donee_r <= 1'b1;
               end
            end
            default: begin
               z_r            <= ZERO_Z;
               prev_r         <= 5'd0;
               donee_r        <= 1'b0;
               write_enable_r <= 1'b0;
               cnt_value_r    <= ZERO_Z;
               par_addr_r     <= ZERO_Z;
               write_addr_r   <= ZERO_Z;
               write_value_r  <= ZERO_W;
            end
         endcase
      end
   end

   assign donee        = donee_r;
   assign write_enable = write_enable_r;
   assign cnt_value    = cnt_value_r;
   assign par_addr     = par_addr_r;
   assign write_addr   = write_addr_r;
   assign write_value  = write_value_r;

endmodule

// File: tb/tb_col_theta_apply.sv
module tb_col_theta_apply;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        donee;
   logic [5:0]  cnt_value;
   logic [24:0] line_in;
   logic [5:0]  par_addr;
   logic [24:0] par_in;
   logic        write_enable;
   logic [5:0]  write_addr;
   logic [24:0] write_value;

   logic [24:0] mem     [64];
   logic [24:0] par     [64];
   logic [24:0] exp_val [64];

   int checks = 0;
   int errors = 0;

   assign line_in = mem[cnt_value];
   assign par_in  = par[par_addr];

   always #5 clk = ~clk;

   col_theta_apply dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .donee        (donee),
      .cnt_value    (cnt_value),
      .line_in      (line_in),
      .par_addr     (par_addr),
      .par_in       (par_in),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_value  (write_value)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference: theta column step from the slice/parity tables, wrapping z-1.
   task automatic build_expected();
      for (int z = 0; z < 64; z++) begin
         logic [4:0] c_cur;
         logic [4:0] c_prv;
         c_cur = par[z][4:0];
         c_prv = par[(z + 63) % 64][4:0];
         exp_val[z] = mem[z];
         for (int x = 0; x < 5; x++) begin
            logic dx;
            dx = c_cur[(x + 4) % 5] ^ c_prv[(x + 1) % 5];
            for (int y = 0; y < 5; y++) begin
               exp_val[z][5*y + x] = mem[z][5*y + x] ^ dx;
            end
         end
      end
   endtask

   task automatic clear_tables();
      for (int i = 0; i < 64; i++) begin
         mem[i]     = 25'd0;
         par[i]     = 25'd0;
         exp_val[i] = 25'd0;
      end
   endtask

   task automatic randomize_tables();
      for (int i = 0; i < 64; i++) begin
         mem[i] = 25'($urandom);
         par[i] = 25'($urandom);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_donee"},       32'(donee),        32'd0);
      check({tag, "_we"},          32'(write_enable), 32'd0);
      check({tag, "_cnt_value"},   32'(cnt_value),    32'd0);
      check({tag, "_par_addr"},    32'(par_addr),     32'd0);
      check({tag, "_write_addr"},  32'(write_addr),   32'd0);
      check({tag, "_write_value"}, 32'(write_value),  32'd0);
   endtask

   // One run from IDLE. Called just after a falling edge. Cycle 0 is PRIME.
   // drop_early releases start during the run, so DONE lasts one cycle.
   task automatic run_check(input int ncyc, input bit drop_early);
      int pulses;
      pulses = 0;
      start = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         bit exp_we;
         bit exp_done;
         @(negedge clk);
         exp_we   = (cyc >= 2) && (cyc <= 128) && (cyc % 2 == 0);
         exp_done = drop_early ? (cyc == 129) : (cyc >= 129);
         check("write_enable", 32'(write_enable), 32'(exp_we));
         check("donee", 32'(donee), 32'(exp_done));
         if (cyc == 0) begin
            check("prime_par_addr", 32'(par_addr), 32'd63);
         end
         if ((cyc % 2 == 1) && (cyc <= 127)) begin
            check("read_cnt_value", 32'(cnt_value), 32'((cyc - 1) / 2));
            check("read_par_addr",  32'(par_addr),  32'((cyc - 1) / 2));
         end
         if (write_enable === 1'b1) begin
            int idx;
            idx = (pulses > 63) ? 63 : pulses;
            pulses++;
            check("write_addr",  32'(write_addr),  32'(idx));
            check("write_value", 32'(write_value), 32'(exp_val[idx]));
         end
         if (drop_early && cyc == 5) begin
            start = 1'b0;
         end
      end
      check("pulse_count", 32'(pulses), 32'd64);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b1;
      clear_tables();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check_idle_outputs("reset");

      // All-zero slices and parity.
      clear_tables();
      run_check(132, 1'b1);
      check_idle_outputs("zero_idle");

      // Single bit in slice 0 with parity on slice 0.
      clear_tables();
      mem[0] = 25'h0000001;
      par[0] = 25'h0000001;
      exp_val[0] = 25'h0210843;
      exp_val[1] = 25'h1084210;
      run_check(132, 1'b1);

      // Wrap: slice 63 feeds slice 0 through the primed parity.
      clear_tables();
      mem[63] = 25'h0000001;
      par[63] = 25'h0000001;
      exp_val[0]  = 25'h1084210;
      exp_val[63] = 25'h0210843;
      run_check(132, 1'b1);

      // Upper parity bits must be ignored.
      clear_tables();
      for (int i = 0; i < 64; i++) begin
         par[i] = {20'hFFFFF, 5'b00000};
      end
      run_check(132, 1'b1);

      // Random contents against the reference.
      for (int r = 0; r < 3; r++) begin
         randomize_tables();
         build_expected();
         run_check(132, 1'b1);
      end

      // Reset in cycle 41 aborts the run.
      randomize_tables();
      build_expected();
      start = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc <= 41; cyc++) begin
         @(negedge clk);
         check("abort_we", 32'(write_enable),
               32'((cyc >= 2) && (cyc % 2 == 0)));
      end
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("abort_reset");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("abort_quiet_we", 32'(write_enable), 32'd0);
      end
      run_check(132, 1'b1);

      // Start held high for a long time: one run only, donee stays high.
      randomize_tables();
      build_expected();
      run_check(15000, 1'b0);
      start = 1'b0;
      @(negedge clk);
      check("held_release_donee", 32'(donee), 32'd0);
      check_idle_outputs("held_idle");
      run_check(132, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
